uart_param: RTL and testbench

- Parametrised successor to the fixed 8N1 UART. It provides a full-duplex serial port with configurable data width, parity mode and stop-bit count.
- Baud timing comes from an internal 16x oversampling tick generator. TX takes data over a valid/ready handshake. RX reports each frame as a one-cycle valid pulse with error flags.
- Sits between board pins and user logic, one instance per serial channel.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_tick_gen.sv | 34 +++
 rtl/uart_param.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_param.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and baud divider helper for the parametrised UART.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned OVERSAMPLE  = 16;

  // Tick counters: TX needs room for two stop bits, RX never exceeds one bit.
  localparam int unsigned TX_TCNT_W   = 5;
  localparam int unsigned RX_TCNT_W   = 4;
  localparam int unsigned BCNT_W      = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Clocks per oversampling tick.
  function automatic int unsigned calc_div(input int unsigned clock_rate,
                                           input int unsigned baud_rate);
    return clock_rate / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running divider producing a one-clock tick every DIV clocks.
module uart_tick_gen
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rstN,
  output logic tick
);

  localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  // Next count wraps at DIV-1.
  always_comb begin
    cnt_d = cnt + CNT_W'(1);
    if (cnt == LAST) cnt_d = '0;
  end

  // Counter plus registered tick, so tick is high exactly while the count is DIV-1.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt  <= '0;
      tick <= (LAST == '0);
    end else begin
      cnt  <= cnt_d;
      tick <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/uart_param.sv
// Full-duplex UART with configurable data width, parity and stop bits, 16x oversampled.
module uart_param
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rx,
  input  logic                 rxEn,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  output logic                 rxParityErr,
  output logic                 rxFrameErr,
  output logic                 rxBusy,
  output logic                 tx,
  input  logic                 txEn,
  input  logic                 txValid,
  output logic                 txReady,
  input  logic [DATA_BITS-1:0] txData,
  output logic                 txBusy
);

  localparam int unsigned DIV = calc_div(CLOCK_RATE, BAUD_RATE);

  localparam logic [TX_TCNT_W-1:0] TX_BIT_LAST  = TX_TCNT_W'(OVERSAMPLE - 1);
  localparam logic [TX_TCNT_W-1:0] TX_STOP_LAST = TX_TCNT_W'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [RX_TCNT_W-1:0] RX_BIT_LAST  = RX_TCNT_W'(OVERSAMPLE - 1);
  localparam logic [RX_TCNT_W-1:0] RX_HALF_LAST = RX_TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BCNT_W-1:0]    DATA_LAST    = BCNT_W'(DATA_BITS - 1);
  localparam bit                   HAS_PARITY   = (PARITY != PARITY_NONE);
  localparam logic                 PAR_ODD      = (PARITY == PARITY_ODD);

  // Reject configurations the datapath cannot represent.
  if (DIV < 1) begin : g_div_err
    $error("uart_param: CLOCK_RATE too low for 16x oversampling at BAUD_RATE");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_err
    $error("uart_param: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_ODD) begin : g_par_err
    $error("uart_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_err
    $error("uart_param: STOP_BITS must be 1 or 2");
  end

  logic tick;

  uart_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rstN (rstN),
    .tick (tick)
  );

  // ---------------------------------------------------------------- TX

  tx_state_t              tx_state, tx_state_d;
  logic [TX_TCNT_W-1:0]   tx_tcnt, tx_tcnt_d;
  logic [BCNT_W-1:0]      tx_bcnt, tx_bcnt_d;
  logic [DATA_BITS-1:0]   tx_shift, tx_shift_d;
  logic                   tx_par, tx_par_d;
  logic                   tx_d;
  logic                   tx_run;
  logic [TX_TCNT_W-1:0]   tx_bit_last;
  logic                   tx_bit_end;

  // Holds off txReady until the first clock after reset release.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) tx_run <= 1'b0;
    else       tx_run <= 1'b1;
  end

  assign txReady     = tx_run & txEn & (tx_state == TX_IDLE);
  assign txBusy      = (tx_state != TX_IDLE);
  assign tx_bit_last = (tx_state == TX_STOP) ? TX_STOP_LAST : TX_BIT_LAST;
  assign tx_bit_end  = tick && (tx_tcnt == tx_bit_last);

  // TX next-state, bit sequencing and next line value.
  always_comb begin
    tx_state_d = tx_state;
    tx_tcnt_d  = tx_tcnt;
    tx_bcnt_d  = tx_bcnt;
    tx_shift_d = tx_shift;
    tx_par_d   = tx_par;
    tx_d       = 1'b1;

    if (tx_state != TX_IDLE && tick) begin
      tx_tcnt_d = tx_bit_end ? '0 : tx_tcnt + TX_TCNT_W'(1);
    end

    case (tx_state)
      TX_IDLE: begin
        if (txValid && txReady) begin
          tx_state_d = TX_START;
          tx_tcnt_d  = '0;
          tx_bcnt_d  = '0;
          tx_shift_d = txData;
          tx_par_d   = (^txData) ^ PAR_ODD;
        end
      end
      TX_START: begin
        if (tx_bit_end) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bcnt == DATA_LAST) begin
            tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
          end else begin
            tx_bcnt_d  = tx_bcnt + BCNT_W'(1);
            tx_shift_d = tx_shift >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) tx_state_d = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // TX state and line register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_tcnt  <= tx_tcnt_d;
      tx_bcnt  <= tx_bcnt_d;
      tx_shift <= tx_shift_d;
      tx_par   <= tx_par_d;
      tx       <= tx_d;
    end
  end

  // ---------------------------------------------------------------- RX

  logic                   rx_meta, rx_sync;
  rx_state_t              rx_state, rx_state_d;
  logic [RX_TCNT_W-1:0]   rx_tcnt, rx_tcnt_d;
  logic [BCNT_W-1:0]      rx_bcnt, rx_bcnt_d;
  logic [DATA_BITS-1:0]   rx_shift, rx_shift_d;
  logic                   rx_perr, rx_perr_d;
  logic [DATA_BITS-1:0]   rx_data_d;
  logic                   rx_valid_d, rx_perr_out_d, rx_ferr_d;
  logic [RX_TCNT_W-1:0]   rx_sample_at;
  logic                   rx_sample;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign rxBusy       = (rx_state != RX_IDLE);
  assign rx_sample_at = (rx_state == RX_START) ? RX_HALF_LAST : RX_BIT_LAST;
  assign rx_sample    = tick && (rx_tcnt == rx_sample_at);

  // RX next-state: mid-bit sampling, shift-in and frame reporting.
  always_comb begin
    rx_state_d    = rx_state;
    rx_tcnt_d     = rx_tcnt;
    rx_bcnt_d     = rx_bcnt;
    rx_shift_d    = rx_shift;
    rx_perr_d     = rx_perr;
    rx_data_d     = rxData;
    rx_valid_d    = 1'b0;
    rx_perr_out_d = 1'b0;
    rx_ferr_d     = 1'b0;

    if (tick && rx_state != RX_IDLE && rx_state != RX_WAIT_HIGH) begin
      rx_tcnt_d = rx_sample ? '0 : rx_tcnt + RX_TCNT_W'(1);
    end

    case (rx_state)
      RX_IDLE: begin
        if (rxEn && !rx_sync) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = '0;
          rx_bcnt_d  = '0;
          rx_perr_d  = 1'b0;
        end
      end
      RX_START: begin
        if (rx_sample) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
          if (rx_bcnt == DATA_LAST) rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
          else                      rx_bcnt_d  = rx_bcnt + BCNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_perr_d  = rx_sync ^ (^rx_shift) ^ PAR_ODD;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_valid_d    = 1'b1;
          rx_data_d     = rx_shift;
          rx_perr_out_d = rx_perr;
          rx_ferr_d     = ~rx_sync;
          rx_state_d    = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state and output register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_state    <= RX_IDLE;
      rx_tcnt     <= '0;
      rx_bcnt     <= '0;
      rx_shift    <= '0;
      rx_perr     <= 1'b0;
      rxData      <= '0;
      rxValid     <= 1'b0;
      rxParityErr <= 1'b0;
      rxFrameErr  <= 1'b0;
    end else begin
      rx_state    <= rx_state_d;
      rx_tcnt     <= rx_tcnt_d;
      rx_bcnt     <= rx_bcnt_d;
      rx_shift    <= rx_shift_d;
      rx_perr     <= rx_perr_d;
      rxData      <= rx_data_d;
      rxValid     <= rx_valid_d;
      rxParityErr <= rx_perr_out_d;
      rxFrameErr  <= rx_ferr_d;
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Scoreboard bench for uart_param: three instances (8N1, 7O1, 8N2), DIV=1 so one bit = 16 clk.
module tb_uart_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic [2:0] loop, drv, rx_in, rx_en, tx_en, tx_valid;
  logic [2:0] tx, tx_ready, tx_busy, rx_valid, rx_perr, rx_ferr, rx_busy;
  logic [7:0] td_a, td_c, rd_a, rd_c;
  logic [6:0] td_b, rd_b;

  assign rx_in = (loop & tx) | (~loop & drv);

  int checks   = 0;
  int failures = 0;

  // Expected frames: {frame_err, parity_err, data[8:0]}
  logic [10:0] sb0[$];
  logic [10:0] sb1[$];
  logic [10:0] sb2[$];

  uart_param #(.CLOCK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rstN(rstN), .rx(rx_in[0]), .rxEn(rx_en[0]), .rxData(rd_a), .rxValid(rx_valid[0]),
    .rxParityErr(rx_perr[0]), .rxFrameErr(rx_ferr[0]), .rxBusy(rx_busy[0]), .tx(tx[0]), .txEn(tx_en[0]),
    .txValid(tx_valid[0]), .txReady(tx_ready[0]), .txData(td_a), .txBusy(tx_busy[0]));

  uart_param #(.CLOCK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7o1 (
    .clk(clk), .rstN(rstN), .rx(rx_in[1]), .rxEn(rx_en[1]), .rxData(rd_b), .rxValid(rx_valid[1]),
    .rxParityErr(rx_perr[1]), .rxFrameErr(rx_ferr[1]), .rxBusy(rx_busy[1]), .tx(tx[1]), .txEn(tx_en[1]),
    .txValid(tx_valid[1]), .txReady(tx_ready[1]), .txData(td_b), .txBusy(tx_busy[1]));

  uart_param #(.CLOCK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rstN(rstN), .rx(rx_in[2]), .rxEn(rx_en[2]), .rxData(rd_c), .rxValid(rx_valid[2]),
    .rxParityErr(rx_perr[2]), .rxFrameErr(rx_ferr[2]), .rxBusy(rx_busy[2]), .tx(tx[2]), .txEn(tx_en[2]),
    .txValid(tx_valid[2]), .txReady(tx_ready[2]), .txData(td_c), .txBusy(tx_busy[2]));

  function automatic logic [8:0] rdata(input int i);
    case (i)
      0:       return {1'b0, rd_a};
      1:       return {2'b0, rd_b};
      default: return {1'b0, rd_c};
    endcase
  endfunction

  task automatic set_data(input int i, input logic [8:0] d);
    case (i)
      0:       td_a = d[7:0];
      1:       td_b = d[6:0];
      default: td_c = d[7:0];
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic fe, input logic pe, input logic [8:0] d);
    case (i)
      0:       sb0.push_back({fe, pe, d});
      1:       sb1.push_back({fe, pe, d});
      default: sb2.push_back({fe, pe, d});
    endcase
  endtask

  // Monitor: every rxValid pulse is matched against the oldest expected frame.
  task automatic check_pulse(input int i);
    logic [10:0] e;
    bit          have;
    have = 1'b0;
    e    = '0;
    case (i)
      0:       if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
      1:       if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
      default: if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL rx%0d_unexpected_pulse: got data 0x%0h pe=%0b fe=%0b, required no pulse (t=%0t)",
               i, rdata(i), rx_perr[i], rx_ferr[i], $time);
    end else begin
      chk($sformatf("rx%0d_data", i), 32'(rdata(i)), 32'(e[8:0]));
      chk($sformatf("rx%0d_parity_err", i), 32'(rx_perr[i]), 32'(e[9]));
      chk($sformatf("rx%0d_frame_err", i), 32'(rx_ferr[i]), 32'(e[10]));
    end
  endtask

  always @(negedge clk) begin
    if (rstN) begin
      for (int i = 0; i < 3; i++) begin
        if (rx_valid[i]) check_pulse(i);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for txReady; the following edge accepts. Returns one cycle after acceptance.
  task automatic wait_accept(input int i, input bit keep_valid, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (tx_ready[i]) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL tx%0d_accept_timeout: got txReady=0 for 2000 clk, required 1", i);
    end else begin
      cyc(1);
      if (!keep_valid) tx_valid[i] = 1'b0;
    end
  endtask

  // Checks first and last clk of every bit, then txReady returning.
  task automatic check_frame(input int i, input logic [15:0] bits, input int n);
    for (int c = 0; c < n * 16; c++) begin
      if (c % 16 == 0 || c % 16 == 15)
        chk($sformatf("tx%0d_bit%0d_clk%0d", i, c / 16, c % 16), 32'(tx[i]), 32'(bits[c / 16]));
      if (c == n * 16 - 1) chk($sformatf("tx%0d_ready_before_end", i), 32'(tx_ready[i]), 32'd0);
      cyc(1);
    end
    chk($sformatf("tx%0d_ready_return", i), 32'(tx_ready[i]), 32'd1);
  endtask

  task automatic drive_frame(input int i, input logic [15:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      drv[i] = bits[k];
      cyc(16);
    end
    drv[i] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int busy, hi, gap;

    rstN = 1'b0;
    loop = 3'b111;
    drv = 3'b111;
    rx_en = 3'b111;
    tx_en = 3'b111;
    tx_valid = 3'b000;
    td_a = '0;
    td_b = '0;
    td_c = '0;
    cyc(3);

    // Reset values
    chk("rst_tx", 32'(tx), 32'h7);
    chk("rst_tx_ready", 32'(tx_ready), 32'h0);
    chk("rst_tx_busy", 32'(tx_busy), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_rx_perr", 32'(rx_perr), 32'h0);
    chk("rst_rx_ferr", 32'(rx_ferr), 32'h0);
    chk("rst_rx_busy", 32'(rx_busy), 32'h0);
    chk("rst_rx_data0", 32'(rdata(0)), 32'h0);
    chk("rst_rx_data1", 32'(rdata(1)), 32'h0);
    chk("rst_rx_data2", 32'(rdata(2)), 32'h0);
    rstN = 1'b1;
    cyc(2);

    // 1: 8N1 loopback, 0xA5 -> 0,1,0,1,0,0,1,0,1,1
    push(0, 1'b0, 1'b0, 9'h0A5);
    set_data(0, 9'h0A5);
    tx_valid[0] = 1'b1;
    wait_accept(0, 1'b0, ok);
    if (ok) check_frame(0, 16'h034A, 10);
    cyc(20);
    chk("rx0_data_hold", 32'(rdata(0)), 32'h0A5);

    // 2: 7O1, 0x55 has even weight so odd parity bit is 1
    push(1, 1'b0, 1'b0, 9'h055);
    set_data(1, 9'h055);
    tx_valid[1] = 1'b1;
    wait_accept(1, 1'b0, ok);
    if (ok) check_frame(1, 16'h03AA, 10);
    cyc(20);
    loop[1] = 1'b0;
    cyc(4);
    push(1, 1'b0, 1'b1, 9'h055);
    drive_frame(1, 16'h02AA, 10);
    cyc(20);

    // 3: glitch then break on the 8N1 receiver
    loop[0] = 1'b0;
    cyc(4);
    drv[0] = 1'b0;
    cyc(4);
    chk("glitch_busy", 32'(rx_busy[0]), 32'd1);
    drv[0] = 1'b1;
    cyc(16);
    chk("glitch_idle", 32'(rx_busy[0]), 32'd0);
    push(0, 1'b1, 1'b0, 9'h000);
    drv[0] = 1'b0;
    cyc(400);
    chk("break_wait_high", 32'(rx_busy[0]), 32'd1);
    drv[0] = 1'b1;
    cyc(4);
    chk("break_release", 32'(rx_busy[0]), 32'd0);
    push(0, 1'b0, 1'b0, 9'h03C);
    drive_frame(0, 16'h0278, 10);
    cyc(20);
    loop[0] = 1'b1;

    // 4: 8N2 back-to-back 0x00 then 0xFF with txValid held
    push(2, 1'b0, 1'b0, 9'h000);
    push(2, 1'b0, 1'b0, 9'h0FF);
    set_data(2, 9'h000);
    tx_valid[2] = 1'b1;
    wait_accept(2, 1'b1, ok);
    set_data(2, 9'h0FF);
    busy = 0;
    hi = 0;
    while (tx_busy[2] && busy < 1000) begin
      busy++;
      if (tx[2]) hi++;
      cyc(1);
    end
    chk("b2b_frame1_len", 32'(busy), 32'd176);
    chk("b2b_frame1_stop_high", 32'(hi), 32'd32);
    gap = 0;
    while (!tx_busy[2] && gap < 1000) begin
      gap++;
      cyc(1);
    end
    chk("b2b_handshake_gap", 32'(gap), 32'd1);
    tx_valid[2] = 1'b0;
    busy = 0;
    hi = 0;
    while (tx_busy[2] && busy < 1000) begin
      busy++;
      if (tx[2]) hi++;
      cyc(1);
    end
    chk("b2b_frame2_len", 32'(busy), 32'd176);
    chk("b2b_frame2_high", 32'(hi), 32'd160);
    cyc(30);

    // 5: reset during a data bit of both TX and RX
    set_data(0, 9'h0C3);
    tx_valid[0] = 1'b1;
    wait_accept(0, 1'b0, ok);
    cyc(40);
    chk("pre_rst_rx_busy", 32'(rx_busy[0]), 32'd1);
    rstN = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx[0]), 32'd1);
    chk("mid_rst_tx_busy", 32'(tx_busy[0]), 32'd0);
    chk("mid_rst_rx_busy", 32'(rx_busy[0]), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready[0]), 32'd0);
    cyc(1);
    rstN = 1'b1;
    cyc(2);
    push(0, 1'b0, 1'b0, 9'h0C3);
    tx_valid[0] = 1'b1;
    wait_accept(0, 1'b0, ok);
    if (ok) check_frame(0, 16'h0386, 10);
    cyc(20);

    // 6: txEn gates acceptance
    tx_en[0] = 1'b0;
    set_data(0, 9'h00F);
    tx_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(5);
      chk("txen_low_ready", 32'(tx_ready[0]), 32'd0);
      chk("txen_low_line", 32'(tx[0]), 32'd1);
    end
    tx_en[0] = 1'b1;
    #1;
    chk("txen_high_ready", 32'(tx_ready[0]), 32'd1);
    push(0, 1'b0, 1'b0, 9'h00F);
    wait_accept(0, 1'b0, ok);
    if (ok) check_frame(0, 16'h021E, 10);
    cyc(50);

    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    chk("sb2_drained", 32'(sb2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
